// File: rtl/pc_fetch_unit.sv
// Program counter and single-entry fetch register with start/run/halt control.
// Handles absolute jumps, if_pc-relative branches, stalls and the end-of-program address.
module pc_fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'd0,
  parameter logic [15:0] PC_LAST  = 16'd34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [7:0]  branch_offset,
  input  logic        halt_req,
  input  logic        rom_format,
  input  logic [3:0]  rom_opcode,
  input  logic        rom_sign,
  input  logic [2:0]  rom_operand,
  input  logic [7:0]  rom_immediate,
  output logic [15:0] pc_out,
  output logic        if_format,
  output logic [3:0]  if_opcode,
  output logic        if_sign,
  output logic [2:0]  if_operand,
  output logic [7:0]  if_immediate,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        if_format_q, if_format_d;
  logic [3:0]  if_opcode_q, if_opcode_d;
  logic        if_sign_q, if_sign_d;
  logic [2:0]  if_operand_q, if_operand_d;
  logic [7:0]  if_immediate_q, if_immediate_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [15:0] branch_pc;
  assign branch_pc = if_pc_q + {{8{branch_offset[7]}}, branch_offset};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= PC_RESET;
      if_format_q    <= 1'b0;
      if_opcode_q    <= 4'd0;
      if_sign_q      <= 1'b0;
      if_operand_q   <= 3'd0;
      if_immediate_q <= 8'd0;
      if_pc_q        <= 16'd0;
      if_valid_q     <= 1'b0;
      fetch_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_format_q    <= if_format_d;
      if_opcode_q    <= if_opcode_d;
      if_sign_q      <= if_sign_d;
      if_operand_q   <= if_operand_d;
      if_immediate_q <= if_immediate_d;
      if_pc_q        <= if_pc_d;
      if_valid_q     <= if_valid_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  // Priority in RUN: start, halt_req, jump, branch (only with a live if_pc), stall, fetch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_format_d    = if_format_q;
    if_opcode_d    = if_opcode_q;
    if_sign_d      = if_sign_q;
    if_operand_d   = if_operand_q;
    if_immediate_d = if_immediate_q;
    if_pc_d        = if_pc_q;
    if_valid_d     = if_valid_q;
    fetch_count_d  = fetch_count_q;

    case (state_q)
      IDLE: begin
        pc_d       = PC_RESET;
        if_valid_d = 1'b0;
        if (start) begin
          state_d       = RUN;
          fetch_count_d = 16'd0;
        end
      end
      RUN: begin
        if (start) begin
          pc_d          = PC_RESET;
          if_valid_d    = 1'b0;
          fetch_count_d = 16'd0;
        end else if (halt_req) begin
          state_d    = HALT;
          if_valid_d = 1'b0;
        end else if (jump_en) begin
          pc_d       = jump_target;
          if_valid_d = 1'b0;
        end else if (branch_taken && if_valid_q) begin
          pc_d       = branch_pc;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_format_d    = rom_format;
          if_opcode_d    = rom_opcode;
          if_sign_d      = rom_sign;
          if_operand_d   = rom_operand;
          if_immediate_d = rom_immediate;
          if_pc_d        = pc_q;
          if_valid_d     = 1'b1;
          fetch_count_d  = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;
          if (pc_q == PC_LAST) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + 16'd1;
          end
        end
      end
      HALT: begin
        if (start) begin
          state_d       = RUN;
          pc_d          = PC_RESET;
          if_valid_d    = 1'b0;
          fetch_count_d = 16'd0;
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pc_out       = pc_q;
  assign if_format    = if_format_q;
  assign if_opcode    = if_opcode_q;
  assign if_sign      = if_sign_q;
  assign if_operand   = if_operand_q;
  assign if_immediate = if_immediate_q;
  assign if_pc        = if_pc_q;
  assign if_valid     = if_valid_q;
  assign halted       = (state_q == HALT);
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table plus hand-written multi-cycle sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, jump_en, branch_taken, halt_req;
  logic [15:0] jump_target;
  logic [7:0]  branch_offset;
  logic        rom_format, rom_sign;
  logic [3:0]  rom_opcode;
  logic [2:0]  rom_operand;
  logic [7:0]  rom_immediate;
  logic [15:0] pc_out, if_pc, fetch_count;
  logic        if_format, if_sign, if_valid, halted;
  logic [3:0]  if_opcode;
  logic [2:0]  if_operand;
  logic [7:0]  if_immediate;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start, stall, jump_en;
    logic [15:0] jump_target;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic        halt_req;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic [15:0] exp_if_pc;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .jump_en(jump_en), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .halt_req(halt_req),
    .rom_format(rom_format), .rom_opcode(rom_opcode), .rom_sign(rom_sign),
    .rom_operand(rom_operand), .rom_immediate(rom_immediate),
    .pc_out(pc_out),
    .if_format(if_format), .if_opcode(if_opcode), .if_sign(if_sign),
    .if_operand(if_operand), .if_immediate(if_immediate), .if_pc(if_pc),
    .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Fake ROM whose fields are all a distinct function of the address.
  always_comb begin
    rom_format    = pc_out[0];
    rom_opcode    = pc_out[3:0] ^ 4'h9;
    rom_sign      = pc_out[1];
    rom_operand   = pc_out[6:4];
    rom_immediate = pc_out[7:0] + 8'h30;
  end

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] epc, input logic ev,
                             input logic [15:0] eifpc, input logic eh, input logic [15:0] ecnt);
    checkVal({name, ".pc_out"}, pc_out, epc);
    checkVal({name, ".if_valid"}, {15'd0, if_valid}, {15'd0, ev});
    checkVal({name, ".if_pc"}, if_pc, eifpc);
    checkVal({name, ".halted"}, {15'd0, halted}, {15'd0, eh});
    checkVal({name, ".fetch_count"}, fetch_count, ecnt);
    if (ev) begin
      checkVal({name, ".if_opcode"}, {12'd0, if_opcode}, {12'd0, eifpc[3:0] ^ 4'h9});
      checkVal({name, ".if_immediate"}, {8'd0, if_immediate}, {8'd0, eifpc[7:0] + 8'h30});
      checkVal({name, ".if_misc"}, {11'd0, if_format, if_sign, if_operand},
               {11'd0, eifpc[0], eifpc[1], eifpc[6:4]});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start         = v.start;
    stall         = v.stall;
    jump_en       = v.jump_en;
    jump_target   = v.jump_target;
    branch_taken  = v.branch_taken;
    branch_offset = v.branch_offset;
    halt_req      = v.halt_req;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    start = 0; stall = 0; jump_en = 0; jump_target = 16'd0;
    branch_taken = 0; branch_offset = 8'd0; halt_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic st, input logic sl, input logic je, input logic [15:0] jt,
                        input logic bt, input logic [7:0] bo, input logic hr,
                        input logic [15:0] epc, input logic ev, input logic [15:0] eifpc,
                        input logic eh, input logic [15:0] ecnt);
    vec_t v;
    v.start = st; v.stall = sl; v.jump_en = je; v.jump_target = jt;
    v.branch_taken = bt; v.branch_offset = bo; v.halt_req = hr;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_if_pc = eifpc; v.exp_halted = eh; v.exp_cnt = ecnt;
    vecs.push_back(v);
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;

    //     st sl je jt  bt bo     hr  pc v ifpc h cnt
    addVec(0, 0, 0, 0,  0, 8'h00, 0,  0, 0, 0,  0, 0);   // IDLE holds
    addVec(1, 0, 0, 0,  0, 8'h00, 0,  0, 0, 0,  0, 0);   // start
    addVec(0, 0, 0, 0,  0, 8'h00, 0,  1, 1, 0,  0, 1);
    addVec(0, 0, 0, 0,  0, 8'h00, 0,  2, 1, 1,  0, 2);
    addVec(0, 1, 0, 0,  0, 8'h00, 0,  2, 1, 1,  0, 2);   // stall
    addVec(0, 0, 0, 0,  1, 8'h03, 0,  4, 0, 1,  0, 2);   // branch +3
    addVec(0, 0, 0, 0,  1, 8'h03, 0,  5, 1, 4,  0, 3);   // branch ignored, if_valid=0
    addVec(0, 1, 1, 20, 0, 8'h00, 0, 20, 0, 4,  0, 3);   // jump overrides stall
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 21, 1, 20, 0, 4);
    addVec(0, 0, 0, 0,  1, 8'hFB, 0, 15, 0, 20, 0, 4);   // branch -5
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 16, 1, 15, 0, 5);
    addVec(0, 0, 1, 9,  0, 8'h00, 1, 16, 0, 15, 1, 5);   // halt beats jump
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 16, 0, 15, 1, 5);
    addVec(0, 0, 1, 9,  0, 8'h00, 0, 16, 0, 15, 1, 5);   // jump ignored in HALT
    addVec(1, 0, 0, 0,  0, 8'h00, 0,  0, 0, 15, 0, 0);   // restart
    addVec(0, 0, 0, 0,  0, 8'h00, 0,  1, 1, 0,  0, 1);
    addVec(0, 0, 1, 33, 0, 8'h00, 0, 33, 0, 0,  0, 1);
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 34, 1, 33, 0, 2);
    addVec(0, 1, 0, 0,  0, 8'h00, 0, 34, 1, 33, 0, 2);   // stall at PC_LAST: no halt
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 34, 1, 34, 1, 3);   // fetch PC_LAST -> HALT
    addVec(0, 1, 0, 0,  0, 8'h00, 0, 34, 1, 34, 1, 3);   // final instr held by stall
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 34, 0, 34, 1, 3);
    addVec(1, 0, 0, 0,  0, 8'h00, 0,  0, 0, 34, 0, 0);
    addVec(0, 0, 1, 34, 0, 8'h00, 0, 34, 0, 34, 0, 0);   // jump to PC_LAST: no halt
    addVec(0, 0, 0, 0,  0, 8'h00, 0, 34, 1, 34, 1, 1);
    addVec(1, 0, 0, 0,  0, 8'h00, 1,  0, 0, 34, 0, 0);   // start beats halt_req in HALT
    addVec(1, 0, 0, 0,  0, 8'h00, 1,  0, 0, 34, 0, 0);   // start beats halt_req in RUN
    addVec(0, 0, 0, 0,  0, 8'h00, 0,  1, 1, 0,  0, 1);

    #12;
    checkOutput("reset", 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    checkVal("reset.if_immediate", {8'd0, if_immediate}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                  vecs[i].exp_if_pc, vecs[i].exp_halted, vecs[i].exp_cnt);
    end

    // Full program from start to PC_LAST.
    clearInputs();
    start = 1; step(); start = 0;
    checkOutput("run.start", 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    for (int k = 1; k <= 35; k++) begin
      step();
      checkOutput($sformatf("run.k%0d", k), (k <= 34) ? 16'(k) : 16'd34, 1'b1,
                  16'(k - 1), (k == 35), 16'(k));
    end
    step();
    checkOutput("run.end", 16'd34, 1'b0, 16'd34, 1'b1, 16'd35);

    // Branch back from if_pc=10, then a three-cycle stall at pc 7, then halt at 12.
    start = 1; step(); start = 0;
    for (int k = 0; k < 11; k++) step();
    checkOutput("br.pre", 16'd11, 1'b1, 16'd10, 1'b0, 16'd11);
    branch_taken = 1; branch_offset = 8'hFB; step(); branch_taken = 0;
    checkOutput("br.taken", 16'd5, 1'b0, 16'd10, 1'b0, 16'd11);
    step();
    checkOutput("br.after", 16'd6, 1'b1, 16'd5, 1'b0, 16'd12);
    step();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("stall.c%0d", k), 16'd7, 1'b1, 16'd6, 1'b0, 16'd13);
    end
    stall = 0; step();
    checkOutput("stall.resume", 16'd8, 1'b1, 16'd7, 1'b0, 16'd14);
    for (int k = 0; k < 4; k++) step();
    checkOutput("halt.pre", 16'd12, 1'b1, 16'd11, 1'b0, 16'd18);
    halt_req = 1; step(); halt_req = 0;
    checkOutput("halt.req", 16'd12, 1'b0, 16'd11, 1'b1, 16'd18);
    start = 1; step(); start = 0;
    checkOutput("halt.restart", 16'd0, 1'b0, 16'd11, 1'b0, 16'd0);
    step(); step();
    checkOutput("rst.pre", 16'd2, 1'b1, 16'd1, 1'b0, 16'd2);

    // Half-cycle asynchronous reset pulse in the middle of a run.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 checkOutput("rst.async", 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("rst.idle%0d", k), 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
